// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, single-word imem reads, DOR/ack handoff to the decoder
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        DOR,
    output logic [31:0] data_out,
    output logic [31:0] pc_out,
    input  logic        ack_from_next
);

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] imem_addr_next;
    logic        imem_rd_next;
    logic        dor_next;
    logic [31:0] data_out_next;
    logic [31:0] pc_out_next;

    // Register the FSM state, the PC and every output so nothing combinational leaves the block
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            imem_addr <= 32'h0;
            imem_rd   <= 1'b0;
            DOR       <= 1'b0;
            data_out  <= 32'h0;
            pc_out    <= 32'h0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= imem_addr_next;
            imem_rd   <= imem_rd_next;
            DOR       <= dor_next;
            data_out  <= data_out_next;
            pc_out    <= pc_out_next;
        end
    end

    // Next-state and next-output logic; a redirect overrides every state's normal behaviour
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        imem_addr_next = imem_addr;
        imem_rd_next   = 1'b0;
        dor_next       = DOR;
        data_out_next  = data_out;
        pc_out_next    = pc_out;

        if (redirect) begin
            pc_next  = {redirect_pc[31:2], 2'b00};
            dor_next = 1'b0;
            case (state)
                // A read is still in flight; its response must be swallowed before reissuing
                WAIT:    state_next = imem_valid ? REQ : DRAIN;
                DRAIN:   state_next = imem_valid ? REQ : DRAIN;
                default: state_next = REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    imem_rd_next   = 1'b1;
                    imem_addr_next = pc;
                    state_next     = WAIT;
                end
                WAIT: begin
                    if (imem_valid) begin
                        data_out_next = imem_data;
                        pc_out_next   = imem_addr;
                        dor_next      = 1'b1;
                        state_next    = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_from_next) begin
                        dor_next   = 1'b0;
                        pc_next    = pc + PC_STEP;
                        state_next = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state_next = REQ;
                    end
                end
                default: state_next = REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        DOR;
    logic [31:0] data_out;
    logic [31:0] pc_out;
    logic        ack_from_next;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .RESET_PC(32'h0000_0040),
        .PC_STEP (32'd4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .DOR          (DOR),
        .data_out     (data_out),
        .pc_out       (pc_out),
        .ack_from_next(ack_from_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: after lat cycles pulse imem_valid once; returns on the negedge after the pulse
    task automatic mem_respond(input int lat, input logic [31:0] d);
        repeat (lat) @(negedge clk);
        imem_valid = 1'b1;
        imem_data  = d;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'h0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"},   {31'h0, imem_rd}, 32'h0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_dor"},  {31'h0, DOR}, 32'h0);
        check({tag, "_data"}, data_out, 32'h0);
        check({tag, "_pc"},   pc_out, 32'h0);
    endtask

    initial begin
        reset         = 1'b0;
        imem_data     = 32'h0;
        imem_valid    = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        ack_from_next = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check("rel_rd",   {31'h0, imem_rd}, 32'h1);
        check("rel_addr", imem_addr, 32'h40);
        check("rel_dor",  {31'h0, DOR}, 32'h0);

        // First word, then asynchronous reset while it is presented
        mem_respond(2, 32'hAAAA_AAAA);
        check("w0_dor",  {31'h0, DOR}, 32'h1);
        check("w0_data", data_out, 32'hAAAA_AAAA);
        check("w0_pc",   pc_out, 32'h40);
        #2 reset = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel2_rd",   {31'h0, imem_rd}, 32'h1);
        check("rel2_addr", imem_addr, 32'h40);
        check("rel2_dor",  {31'h0, DOR}, 32'h0);

        // Redirect while waiting; stale response must be discarded
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        check("rw_dor1", {31'h0, DOR}, 32'h0);
        check("rw_rd1",  {31'h0, imem_rd}, 32'h0);
        @(negedge clk);
        check("rw_rd2",  {31'h0, imem_rd}, 32'h0);
        imem_valid = 1'b1;
        imem_data  = 32'h0000_DEAD;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        check("rw_dor3",  {31'h0, DOR}, 32'h0);
        check("rw_data3", data_out, 32'h0);
        @(negedge clk);
        check("rw_rd",   {31'h0, imem_rd}, 32'h1);
        check("rw_addr", imem_addr, 32'h100);
        mem_respond(1, 32'h0000_5555);
        check("rw_wdor",  {31'h0, DOR}, 32'h1);
        check("rw_wdata", data_out, 32'h0000_5555);
        check("rw_wpc",   pc_out, 32'h100);

        // Backpressure: ack held off for 6 cycles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_dor",  {31'h0, DOR}, 32'h1);
            check("bp_data", data_out, 32'h0000_5555);
            check("bp_pc",   pc_out, 32'h100);
            check("bp_rd",   {31'h0, imem_rd}, 32'h0);
        end
        ack_from_next = 1'b1;
        @(negedge clk);
        ack_from_next = 1'b0;
        check("bp_ack_dor", {31'h0, DOR}, 32'h0);
        check("bp_ack_rd",  {31'h0, imem_rd}, 32'h0);
        @(negedge clk);
        check("bp_next_rd",   {31'h0, imem_rd}, 32'h1);
        check("bp_next_addr", imem_addr, 32'h104);

        // Stray ack in WAIT, stray imem_valid in PRESENT
        ack_from_next = 1'b1;
        @(negedge clk);
        ack_from_next = 1'b0;
        check("sa_dor", {31'h0, DOR}, 32'h0);
        check("sa_rd",  {31'h0, imem_rd}, 32'h0);
        mem_respond(1, 32'h0000_6666);
        check("sa_wdor",  {31'h0, DOR}, 32'h1);
        check("sa_wdata", data_out, 32'h0000_6666);
        check("sa_wpc",   pc_out, 32'h104);
        mem_respond(0, 32'h0000_0BAD);
        check("sv_dor",  {31'h0, DOR}, 32'h1);
        check("sv_data", data_out, 32'h0000_6666);
        check("sv_pc",   pc_out, 32'h104);
        check("sv_rd",   {31'h0, imem_rd}, 32'h0);

        // Redirect from PRESENT to address 0
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        check("rp_dor", {31'h0, DOR}, 32'h0);
        check("rp_rd",  {31'h0, imem_rd}, 32'h0);
        @(negedge clk);
        check("rp_rd2",   {31'h0, imem_rd}, 32'h1);
        check("rp_addr2", imem_addr, 32'h0);

        // Sequential fetch 0x11/0x22/0x33 from 0x0/0x4/0x8
        for (int i = 0; i < 3; i++) begin
            mem_respond(2, 32'h11 * (i + 1));
            check("seq_dor",  {31'h0, DOR}, 32'h1);
            check("seq_data", data_out, 32'h11 * (i + 1));
            check("seq_pc",   pc_out, 32'(4 * i));
            @(negedge clk);
            check("seq_hold", {31'h0, DOR}, 32'h1);
            if (i == 2) break;
            ack_from_next = 1'b1;
            @(negedge clk);
            ack_from_next = 1'b0;
            check("seq_gap1", {31'h0, DOR}, 32'h0);
            @(negedge clk);
            check("seq_gap2", {31'h0, DOR}, 32'h0);
            check("seq_rd",   {31'h0, imem_rd}, 32'h1);
            check("seq_addr", imem_addr, 32'(4 * (i + 1)));
        end

        // Redirect and ack on the same edge at pc 0x8
        ack_from_next = 1'b1;
        redirect      = 1'b1;
        redirect_pc   = 32'h0000_0200;
        @(negedge clk);
        ack_from_next = 1'b0;
        redirect      = 1'b0;
        check("ra_dor", {31'h0, DOR}, 32'h0);
        @(negedge clk);
        check("ra_rd",   {31'h0, imem_rd}, 32'h1);
        check("ra_addr", imem_addr, 32'h200);

        // PC wrap from 0xFFFF_FFFC (low redirect bits masked)
        mem_respond(1, 32'h0000_7777);
        check("wr_pc0", pc_out, 32'h200);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        check("wr_rd",   {31'h0, imem_rd}, 32'h1);
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        mem_respond(1, 32'h0000_8888);
        check("wr_data", data_out, 32'h0000_8888);
        check("wr_pc",   pc_out, 32'hFFFF_FFFC);
        ack_from_next = 1'b1;
        @(negedge clk);
        ack_from_next = 1'b0;
        @(negedge clk);
        check("wrap_rd",   {31'h0, imem_rd}, 32'h1);
        check("wrap_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
